// File: rtl/fsm_seq_ctrl.sv
// Table-driven 3-bit sequencer with a writable 16x6 next-state/output
// table and IDLE/RUN control for free-run, single-step and halt.
module fsm_seq_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [5:0] cfg_data,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       rewind,
  input  logic       clr_err,
  output logic [2:0] saida,
  output logic [2:0] state,
  output logic       running,
  output logic       done,
  output logic       cfg_err,
  output logic [7:0] step_count
);

  typedef enum logic {IDLE, RUN} ctl_t;

  ctl_t       ctl, ctl_nxt;
  logic [5:0] tbl [16];
  logic [5:0] dout;
  logic [2:0] nxt;
  logic       adv, rew, halt, wr, err_set;

  assign dout    = tbl[{state, a}];
  assign nxt     = dout[5:3];
  assign saida   = dout[2:0];
  assign running = (ctl == RUN);

  always_comb begin
    ctl_nxt = ctl;
    adv     = 1'b0;
    rew     = 1'b0;
    halt    = 1'b0;
    wr      = 1'b0;
    err_set = 1'b0;
    case (ctl)
      IDLE: begin
        wr = cfg_we;
        if (rewind) begin
          rew = 1'b1;
        end else begin
          adv = step;
          if (start && !stop)
            ctl_nxt = RUN;
        end
      end
      RUN: begin
        err_set = cfg_we;
        if (stop) begin
          ctl_nxt = IDLE;
        end else if (nxt == state) begin
          ctl_nxt = IDLE;
          halt    = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      default: ctl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ctl <= IDLE;
    else
      ctl <= ctl_nxt;
  end

  // Lookups above use the pre-write contents on a write edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        tbl[i] <= 6'h00;
    end else if (wr) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      step_count <= 8'd0;
    end else if (rew) begin
      state      <= RESET_STATE;
      step_count <= 8'd0;
    end else if (adv) begin
      state <= nxt;
      if (step_count != 8'hff)
        step_count <= step_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= halt;
      cfg_err <= err_set | (cfg_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the sequencer.
module tb_fsm_seq_ctrl;

  localparam logic [2:0] RS = 3'd2;

  logic       clk = 1'b0;
  logic       reset, a, cfg_we;
  logic [3:0] cfg_addr;
  logic [5:0] cfg_data;
  logic       start, stop, step, rewind, clr_err;
  logic [2:0] saida, state;
  logic       running, done, cfg_err;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;

  logic [5:0] mt [16];
  logic [2:0] ms;
  logic       mrun, mdone, merr;
  logic [7:0] mcnt;

  fsm_seq_ctrl #(.RESET_STATE(RS)) dut (
    .clk(clk), .reset(reset), .a(a),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .step(step),
    .rewind(rewind), .clr_err(clr_err),
    .saida(saida), .state(state), .running(running),
    .done(done), .cfg_err(cfg_err), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mt[i] = 6'h00;
    ms = RS; mrun = 0; mdone = 0; merr = 0; mcnt = 0;
  endtask

  task automatic model_edge();
    logic [5:0] e;
    logic [2:0] nx;
    logic       h;
    if (!reset) begin
      model_reset();
      return;
    end
    e  = mt[{ms, a}];
    nx = e[5:3];
    h  = 0;
    if (mrun && cfg_we) merr = 1;
    else if (clr_err) merr = 0;
    if (!mrun) begin
      if (cfg_we) mt[cfg_addr] = cfg_data;
      if (rewind) begin
        ms = RS; mcnt = 0;
      end else begin
        if (step) begin
          ms = nx;
          if (mcnt != 8'd255) mcnt = mcnt + 8'd1;
        end
        if (start && !stop) mrun = 1;
      end
    end else if (stop) begin
      mrun = 0;
    end else if (nx == ms) begin
      mrun = 0; h = 1;
    end else begin
      ms = nx;
      if (mcnt != 8'd255) mcnt = mcnt + 8'd1;
    end
    mdone = h;
  endtask

  function automatic logic [16:0] mvec();
    logic [5:0] e;
    e = mt[{ms, a}];
    return {ms, e[2:0], mrun, mdone, merr, mcnt};
  endfunction

  function automatic logic [16:0] dvec();
    return {state, saida, running, done, cfg_err, step_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; stop = 0; step = 0; rewind = 0; clr_err = 0;
  endtask

  task automatic wr(input logic [3:0] ad, input logic [5:0] d);
    cfg_we = 1; cfg_addr = ad; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic program_table();
    wr(4, 6'h38); wr(5, 6'h38);
    wr(6, 6'h22); wr(7, 6'h22);
    wr(8, 6'h14); wr(9, 6'h3c);
    wr(10, 6'h1d); wr(11, 6'h1d);
    wr(14, 6'h1b); wr(15, 6'h2b);
  endtask

  task automatic do_rewind();
    rewind = 1; tick(); rewind = 0;
  endtask

  task automatic do_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_reset();
    quiet(); a = 0; reset = 0;
    model_reset();
    #12;
    checks++;
    if (dvec() !== {3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", dvec(),
               {3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    reset = 1;
  endtask

  task automatic test_run_a0();
    logic [2:0] seq_s [4] = '{3'd7, 3'd3, 3'd4, 3'd2};
    logic [2:0] seq_o [4] = '{3'd3, 3'd2, 3'd4, 3'd0};
    program_table();
    a = 0; start = 1; tick(); start = 0;
    checks++;
    if (running !== 1'b1 || state !== 3'd2) begin
      errors++;
      $display("FAIL run0_start got run=%b st=%0d want run=1 st=2",
               running, state);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== seq_s[i] || saida !== seq_o[i] ||
          step_count !== 8'(i + 1)) begin
        errors++;
        $display("FAIL run0_seq%0d got st=%0d o=%0d c=%0d want %0d %0d %0d",
                 i, state, saida, step_count, seq_s[i], seq_o[i], i + 1);
      end
    end
    do_stop();
    checks++;
    if (dvec() !== mvec() || running !== 1'b0) begin
      errors++;
      $display("FAIL run0_stop got %h want %h", dvec(), mvec());
    end
  endtask

  task automatic test_run_a1();
    logic [2:0] seq_s [5] = '{3'd7, 3'd5, 3'd3, 3'd4, 3'd7};
    logic [2:0] seq_o [5] = '{3'd3, 3'd5, 3'd2, 3'd4, 3'd3};
    do_rewind();
    a = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== seq_s[i] || saida !== seq_o[i] || running !== 1'b1) begin
        errors++;
        $display("FAIL run1_seq%0d got st=%0d o=%0d want %0d %0d",
                 i, state, saida, seq_s[i], seq_o[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    wr(4, 6'h10);
    checks++;
    if (cfg_err !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL cfgerr_set got err=%b run=%b want 1 1", cfg_err, running);
    end
    clr_err = 1; wr(5, 6'h00); clr_err = 0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfgerr_clr_collide got %b want 1", cfg_err);
    end
    do_stop();
    clr_err = 1; tick(); clr_err = 0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfgerr_clr got %b want 0", cfg_err);
    end
    do_rewind();
    a = 0; step = 1; tick(); step = 0;
    checks++;
    if (state !== 3'd7 || dvec() !== mvec()) begin
      errors++;
      $display("FAIL cfgerr_tbl_kept got st=%0d want 7", state);
    end
  endtask

  task automatic test_autohalt();
    wr(4, 6'h10);
    do_rewind();
    a = 0; start = 1; tick(); start = 0;
    checks++;
    if (running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter got run=%b done=%b want 1 0", running, done);
    end
    tick();
    checks++;
    if (running !== 1'b0 || done !== 1'b1 || state !== 3'd2 ||
        step_count !== 8'd0) begin
      errors++;
      $display("FAIL halt_edge got run=%b done=%b st=%0d c=%0d want 0 1 2 0",
               running, done, state, step_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_done_pulse got done=%b want 0", done);
    end
    wr(4, 6'h38);
  endtask

  task automatic test_step();
    logic [2:0] seq [3] = '{3'd7, 3'd3, 3'd4};
    do_rewind();
    a = 0;
    for (int i = 0; i < 3; i++) begin
      step = 1; tick(); step = 0;
      checks++;
      if (state !== seq[i] || step_count !== 8'(i + 1) || running !== 1'b0) begin
        errors++;
        $display("FAIL step%0d got st=%0d c=%0d want %0d %0d",
                 i, state, step_count, seq[i], i + 1);
      end
    end
    rewind = 1; step = 1; start = 1; tick();
    rewind = 0; step = 0; start = 0;
    checks++;
    if (state !== 3'd2 || step_count !== 8'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL rewind got st=%0d c=%0d run=%b want 2 0 0",
               state, step_count, running);
    end
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    checks++;
    if (running !== 1'b0 || state !== 3'd2) begin
      errors++;
      $display("FAIL start_stop got run=%b want 0", running);
    end
    start = 1; step = 1; tick(); start = 0; step = 0;
    checks++;
    if (running !== 1'b1 || state !== 3'd7 || step_count !== 8'd1) begin
      errors++;
      $display("FAIL step_start got run=%b st=%0d want 1 7", running, state);
    end
    do_stop();
  endtask

  task automatic test_saturate();
    do_rewind();
    a = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (step_count !== 8'd255 || running !== 1'b1 || dvec() !== mvec()) begin
      errors++;
      $display("FAIL saturate got c=%0d run=%b want 255 1", step_count, running);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (dvec() !== {3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL midrun_reset got %h want %h", dvec(),
               {3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    model_reset();
    #2 reset = 1;
    a = 1;
    #1;
    checks++;
    if (saida !== 3'd0) begin
      errors++;
      $display("FAIL reset_tbl_saida got %0d want 0", saida);
    end
    a = 0; step = 1; tick(); step = 0;
    checks++;
    if (state !== 3'd0 || step_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_tbl_next got st=%0d want 0", state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      a        = 1'($urandom_range(0, 1));
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 4'($urandom);
      cfg_data = 6'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      step     = ($urandom_range(0, 3) == 0);
      rewind   = ($urandom_range(0, 15) == 0);
      clr_err  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (dvec() !== mvec()) begin
        errors++;
        $display("FAIL random%0d got %h want %h", i, dvec(), mvec());
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_run_a0();
    test_run_a1();
    test_cfg_err();
    test_autohalt();
    test_step();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Table-driven state-machine sequencer with a configuration port and run control. It holds a writable 16×6 next-state/output table, addressed as {state, a}. A control FSM decides when the table may be written and when the state register advances: free-running, single-stepped, or halted. It is the programmable, controllable replacement for the fixed case, gate and ROM variants of our 3-bit sequencers, and sits between the test/config host and the datapath that consumes `saida`.

## Interface
- `RESET_STATE`, default 3'd2: state loaded on reset and on `rewind`.
- `clk`  in  1: clock; all updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `a`  in  1: machine input; LSB of the table address.
- `cfg_we`  in  1: table write strobe.
- `cfg_addr`  in  4: table write address.
- `cfg_data`  in  6: table entry, {next_state[2:0], out[2:0]}.
- `start`  in  1: level sampled each edge; enter RUN.
- `stop`  in  1: level sampled each edge; leave RUN.
- `step`  in  1: perform one transition while IDLE.
- `rewind`  in  1: reload `RESET_STATE` and clear `step_count` while IDLE.
- `clr_err`  in  1: clear `cfg_err`.
- `saida`  out  3: combinational; table[{state,a}][2:0].
- `state`  out  3: current machine state.
- `running`  out  1: high when the control FSM is in RUN.
- `done`  out  1: one-cycle pulse after an auto-halt.
- `cfg_err`  out  1: sticky; a write was attempted while in RUN.
- `step_count`  out  8: transitions taken; saturates at 255.

## Operation
- Table lookup: `dout = table[{state,a}]`. `saida = dout[2:0]`; next state = `dout[5:3]`.
- On reset:
  - all 16 table entries = 6'h00;
  - `state = RESET_STATE`;
  - control FSM = IDLE;
  - `running = 0`, `done = 0`, `cfg_err = 0`, `step_count = 0`;
  - `saida = 0`, since the table is zero.
- Control FSM has two states, IDLE and RUN.
- IDLE, evaluated per edge in this priority order:
  - `cfg_we` writes `table[cfg_addr] <= cfg_data`. This is independent of the items below and may coincide with any of them.
  - `rewind`: `state <= RESET_STATE`, `step_count <= 0`. Takes priority over `step` and `start`.
  - `start` with `stop` low → RUN. `start` and `stop` together → stay in IDLE.
  - `step` (no `rewind`): `state <= dout[5:3]`, `step_count` +1 saturating. If `start` is also high, the step occurs and the FSM enters RUN on the same edge.
- RUN, evaluated per edge:
  - `stop` → IDLE; no transition on that edge.
  - Otherwise, if `dout[5:3] == state` (self-loop) → auto-halt: IDLE, state unchanged, no count, `done = 1` for the following cycle.
  - Otherwise `state <= dout[5:3]`, `step_count` +1 saturating.
  - `cfg_we` is ignored: the table is unchanged and `cfg_err <= 1`.
  - `start`, `step` and `rewind` are ignored.
- `cfg_err`:
  - `clr_err` clears it.
  - If `clr_err` and a RUN-time `cfg_we` occur on the same edge, `cfg_err` ends up set.
- Read-before-write: a transition uses the table contents from before any write on the same edge.
- `step_count` stays at 255 once reached, until `rewind` or reset.
- Reset mid-RUN: immediately returns every register to its reset value, including the table.

## Timing
- `start` sampled at edge k: `running = 1` after edge k; the first RUN transition happens at edge k+1.
- `stop` sampled at edge k: `running = 0` after edge k; the state holds its edge-k value.
- Auto-halt detected at edge k: `running = 0` and `done = 1` after edge k; `done = 0` after edge k+1.
- A table write at edge k is visible to `saida` and to next-state lookup after edge k.
- `saida` follows `a` and `state` combinationally with no added latency.

## Test plan
- Program the following table:
  - [4] and [5] = 6'h38;
  - [6] and [7] = 6'h22;
  - [8] = 6'h14, [9] = 6'h3c;
  - [10] and [11] = 6'h1d;
  - [14] = 6'h1b, [15] = 6'h2b.

  Then pulse `start` with `a = 0`. Required: `state` sequence 2,7,3,4,2,…; `saida` sequence 0,3,2,4,0; `step_count` counts 1,2,3,4.
- Same table, `a = 1` in RUN. Required: `state` sequence 2,7,5,3,4,7,…; `saida` shows 0,3,5,2,4,3.
- Raise `cfg_we` while `running = 1`. Required: table unchanged and `cfg_err = 1`. Pulse `clr_err` → `cfg_err = 0`.
- Write [4] = 6'h10 (self-loop at state 2, `a = 0`), then `start`. Required: `running` falls one edge later; `done` pulses once; `state` stays 2; `step_count` stays 0.
- In IDLE, pulse `step` three times with `a = 0` on the first table → `state` 7,3,4. Then `rewind` → `state = 2`, `step_count = 0`. `start` together with `stop` → remains IDLE.
- Run 300 cycles on the first table → `step_count = 255`. Assert `reset` low mid-run → all outputs 0, `state = 2`, table cleared.
